// File: rtl/line_bridge.sv
// line_bridge: single-line read buffer between a CPU load/store port and a
// request/grant bus. Cached reads that hit the buffered line complete with no
// stall. Any other access stalls the CPU and is issued on the bus: cached read
// misses refill the whole line with an incrementing burst, uncached reads fetch
// a single word, and writes go straight through and invalidate a matching line.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   cpu_en/wen/addr/      CPU request (wen == 0 is a read), held while stalled
//   cpu_cached/wdata
//   cpu_rdata, cpu_stall  read data and pipeline hold
//   bus_req/gnt           address-phase handshake
//   bus_wr/burst/addr/    request fields, stable while bus_req is high
//   wstrb/wdata
//   bus_rvalid/rdata      read beats, increasing address order
//   bus_bvalid            write completion pulse
//
// state | meaning
// IDLE  | serve hits combinationally, launch everything else
// REQ   | bus_req high, waiting for bus_gnt
// RDATA | collecting read beats (full line or single word)
// WRESP | waiting for write completion
// DONE  | one cycle with stall released and the requested word on cpu_rdata
module line_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_cached,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_wr,
  output logic        bus_burst,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_bvalid
);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int TAG_LSB = OFF_W + 2;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, RDATA, WRESP, DONE} state_t;
  state_t state, state_nxt;

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      line_mem [LINE_WORDS];
  logic [OFF_W-1:0] beat;
  logic [TAG_W-1:0] rq_tag;
  logic [OFF_W-1:0] rq_off;
  logic [31:0]      done_data;

  logic [TAG_W-1:0] cpu_tag;
  logic [OFF_W-1:0] cpu_off;
  logic             cpu_rd;
  logic             hit;

  assign cpu_tag = cpu_addr[31:TAG_LSB];
  assign cpu_off = cpu_addr[TAG_LSB-1:2];
  assign cpu_rd  = (cpu_wen == 4'h0);
  assign hit     = cpu_en && cpu_rd && cpu_cached && valid && (tag == cpu_tag);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    bus_req   = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          cpu_rdata = line_mem[cpu_off];
        end else if (cpu_en) begin
          cpu_stall = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
        bus_req   = 1'b1;
        if (bus_gnt) state_nxt = bus_wr ? WRESP : RDATA;
      end
      RDATA: begin
        cpu_stall = 1'b1;
        if (bus_rvalid && (!bus_burst || beat == LAST_BEAT)) state_nxt = DONE;
      end
      WRESP: begin
        cpu_stall = 1'b1;
        if (bus_bvalid) state_nxt = DONE;
      end
      DONE: begin
        cpu_rdata = done_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at launch so the bus sees them stable
  // for the whole address phase regardless of what the CPU does.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid     <= 1'b0;
      tag       <= '0;
      beat      <= '0;
      rq_tag    <= '0;
      rq_off    <= '0;
      done_data <= '0;
      bus_wr    <= 1'b0;
      bus_burst <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_en && !hit) begin
            rq_tag    <= cpu_tag;
            rq_off    <= cpu_off;
            beat      <= '0;
            done_data <= '0;
            bus_wr    <= !cpu_rd;
            bus_burst <= cpu_rd && cpu_cached;
            bus_addr  <= (cpu_rd && cpu_cached) ? {cpu_tag, {TAG_LSB{1'b0}}} : cpu_addr;
            bus_wstrb <= cpu_wen;
            bus_wdata <= cpu_wdata;
          end
        end
        RDATA: begin
          if (bus_rvalid) begin
            if (!bus_burst || beat == rq_off) done_data <= bus_rdata;
            if (bus_burst) begin
              beat <= beat + OFF_W'(1);
              // Line becomes valid on the edge that writes its last word, so
              // the access right after DONE can already hit.
              if (beat == LAST_BEAT) begin
                valid <= 1'b1;
                tag   <= rq_tag;
              end
            end
          end
        end
        WRESP: begin
          if (bus_bvalid && valid && (tag == rq_tag)) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid guards it.
  always_ff @(posedge clk) begin
    if (state == RDATA && bus_rvalid && bus_burst) line_mem[beat] <= bus_rdata;
  end

endmodule

// File: tb/tb_line_bridge.sv
module tb_line_bridge;
  localparam int LW = 4;
  localparam logic [31:0] LINE_MASK = ~(32'(LW * 4) - 32'd1);

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = 4'h0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_cached = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_wr;
  logic        bus_burst;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_bvalid = 1'b0;

  always #5 clk = ~clk;

  line_bridge #(.LINE_WORDS(LW)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_cached(cpu_cached),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_wr(bus_wr), .bus_burst(bus_burst),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_bvalid(bus_bvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;

  // Reference: one buffered line plus a memory whose contents are a hash of
  // the address and a salt that changes whenever memory is written.
  bit          m_valid = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_words [LW];
  logic [31:0] salt = 32'h1234_5678;
  bit          pat_a = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (pat_a) return 32'hA0 + 32'((a >> 2) % LW);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Expected bus request and read data for the access in flight.
  bit          exp_bus_on = 0;
  logic [31:0] exp_baddr = '0, exp_bwdata = '0, exp_rdata = '0;
  logic        exp_bwr = 1'b0, exp_bburst = 1'b0;
  logic [3:0]  exp_bwstrb = 4'h0;
  logic [31:0] last_baddr = '0;
  logic        last_bwr = 1'b0, last_bburst = 1'b0;
  logic [3:0]  last_bwstrb = 4'h0;

  always @(negedge clk) begin
    if (cpu_en && cpu_stall) stall_cnt++;
    if (resetn) begin
      if (bus_req) begin
        last_baddr  = bus_addr;
        last_bwr    = bus_wr;
        last_bburst = bus_burst;
        last_bwstrb = bus_wstrb;
        if (!exp_bus_on) check("spurious_bus_req", bus_req, 1'b0);
        else begin
          check("bus_addr", bus_addr, exp_baddr);
          check("bus_wr", bus_wr, exp_bwr);
          check("bus_burst", bus_burst, exp_bburst);
          if (exp_bwr) begin
            check("bus_wstrb", bus_wstrb, exp_bwstrb);
            check("bus_wdata", bus_wdata, exp_bwdata);
          end
        end
      end
      if (cpu_en && cpu_wen == 4'h0 && !cpu_stall) check("cpu_rdata", cpu_rdata, exp_rdata);
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, ".bus_req"}, bus_req, 1'b0);
    check({pfx, ".bus_wr"}, bus_wr, 1'b0);
    check({pfx, ".bus_burst"}, bus_burst, 1'b0);
    check({pfx, ".bus_addr"}, bus_addr, 32'h0);
    check({pfx, ".bus_wstrb"}, bus_wstrb, 4'h0);
    check({pfx, ".bus_wdata"}, bus_wdata, 32'h0);
    check({pfx, ".cpu_rdata"}, cpu_rdata, 32'h0);
    check({pfx, ".cpu_stall"}, cpu_stall, 1'b0);
  endtask

  task automatic access(input logic [3:0] wen, input logic [31:0] addr, input bit cached,
                        input logic [31:0] wdata, input int gnt_wait, input int gap,
                        input int abort_at, output int stalls, output logic [31:0] rdata_seen);
    bit rd, hit, burst;
    logic [31:0] base;
    int nbeats, exp_st, t, g;
    rd    = (wen == 4'h0);
    base  = addr & LINE_MASK;
    hit   = rd && cached && m_valid && (m_base == base);
    burst = rd && cached && !hit;
    stalls = 0;
    rdata_seen = '0;
    @(posedge clk);
    #1;
    exp_rdata  = hit ? m_words[(addr >> 2) % LW] : mem_word(addr);
    exp_bus_on = !hit;
    exp_baddr  = burst ? base : addr;
    exp_bwr    = !rd;
    exp_bburst = burst;
    exp_bwstrb = wen;
    exp_bwdata = wdata;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_cached = cached; cpu_wdata = wdata;
    stall_cnt = 0;
    if (hit) begin
      nstep();
      check("hit_stall", cpu_stall, 1'b0);
      stalls = stall_cnt;
      rdata_seen = cpu_rdata;
      return;
    end
    t = 0;
    do begin
      nstep();
      t++;
    end while (!bus_req && t < 32);
    if (!bus_req) begin
      check("bus_req_timeout", bus_req, 1'b1);
      exp_bus_on = 0;
      stalls = stall_cnt;
      return;
    end
    repeat (gnt_wait) nstep();
    bus_gnt = 1'b1;
    nstep();
    bus_gnt = 1'b0;
    check("bus_req_drop", bus_req, 1'b0);
    exp_st = 2 + gnt_wait;
    nbeats = burst ? LW : 1;
    for (int i = 0; i < nbeats; i++) begin
      g = int'($urandom_range(0, gap));
      repeat (g) nstep();
      exp_st += g + 1;
      if (i == abort_at) begin
        cpu_en = 1'b0;
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_burst_reset");
        nstep();
        resetn = 1'b1;
        m_valid = 0;
        exp_bus_on = 0;
        stalls = stall_cnt;
        return;
      end
      if (rd) begin
        bus_rvalid = 1'b1;
        bus_rdata  = mem_word(exp_baddr + 32'(4 * i));
      end else begin
        bus_bvalid = 1'b1;
      end
      nstep();
      bus_rvalid = 1'b0;
      bus_bvalid = 1'b0;
      bus_rdata  = $urandom;
    end
    check("done_stall", cpu_stall, 1'b0);
    check("stall_cycles", stall_cnt, exp_st);
    stalls = stall_cnt;
    rdata_seen = cpu_rdata;
    exp_bus_on = 0;
    if (burst) begin
      m_valid = 1;
      m_base  = base;
      for (int i = 0; i < LW; i++) m_words[i] = mem_word(base + 32'(4 * i));
    end
    if (!rd) begin
      if (m_valid && m_base == base) m_valid = 0;
      salt = $urandom;
    end
  endtask

  task automatic idle(input int n, input bit noise);
    @(posedge clk);
    #1;
    cpu_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_bvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
      end
      nstep();
      check("idle_stall", cpu_stall, 1'b0);
    end
    bus_rvalid = 1'b0;
    bus_bvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] rv;
    logic [31:0] bases [4];
    logic [31:0] a;
    int op;
    bases[0] = 32'h0000_1000;
    bases[1] = 32'h0000_1010;
    bases[2] = 32'h0000_2000;
    bases[3] = 32'h8000_1000;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1;
    resetn = 1'b1;

    // Cached miss: grant after 2 cycles, beats A0..A3.
    pat_a = 1;
    access(4'h0, 32'h0000_1008, 1'b1, 32'h0, 2, 0, -1, st, rv);
    check("refill_word", rv, 32'hA2);
    check("refill_stalls", st, 8);
    check("refill_addr", last_baddr, 32'h0000_1000);
    check("refill_burst", last_bburst, 1'b1);

    // Back-to-back hit on the refilled line.
    access(4'h0, 32'h0000_100C, 1'b1, 32'h0, 0, 0, -1, st, rv);
    check("hit_word", rv, 32'hA3);
    check("hit_stalls", st, 0);

    // Uncached read of a buffered address goes to the bus.
    pat_a = 0;
    salt = $urandom;
    access(4'h0, 32'h0000_1004, 1'b0, 32'h0, 1, 1, -1, st, rv);
    check("uncached_burst", last_bburst, 1'b0);
    check("uncached_addr", last_baddr, 32'h0000_1004);
    check("uncached_not_buffered", rv == 32'hA1, 1'b0);
    access(4'h0, 32'h0000_1004, 1'b1, 32'h0, 0, 0, -1, st, rv);
    check("buffer_kept", rv, 32'hA1);
    check("buffer_kept_stalls", st, 0);

    // Stray read beats while idle are ignored.
    idle(4, 1);
    access(4'h0, 32'h0000_1008, 1'b1, 32'h0, 0, 0, -1, st, rv);
    check("stray_beats_word", rv, 32'hA2);
    check("stray_beats_stalls", st, 0);

    // Write invalidates the matching line.
    access(4'h3, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 1, 0, -1, st, rv);
    check("write_wr", last_bwr, 1'b1);
    check("write_strb", last_bwstrb, 4'h3);
    check("write_stalls", st, 4);
    access(4'h0, 32'h0000_1004, 1'b1, 32'h0, 0, 0, -1, st, rv);
    check("miss_after_write", st, 6);

    // Reset after beat 2 of a burst, then the same line refetches in full.
    access(4'h0, 32'h0000_2008, 1'b1, 32'h0, 0, 0, 3, st, rv);
    access(4'h0, 32'h0000_2008, 1'b1, 32'h0, 0, 0, -1, st, rv);
    check("refetch_stalls", st, 6);
    check("refetch_burst", last_bburst, 1'b1);
    check("refetch_addr", last_baddr, 32'h0000_2000);

    // Randomized traffic over a few lines.
    for (int n = 0; n < 250; n++) begin
      a  = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, LW - 1));
      op = int'($urandom_range(0, 9));
      if (op < 5)
        access(4'h0, a, 1'b1, 32'h0, int'($urandom_range(0, 3)), 2, -1, st, rv);
      else if (op < 7)
        access(4'h0, a, 1'b0, 32'h0, int'($urandom_range(0, 3)), 2, -1, st, rv);
      else
        access(4'($urandom_range(1, 15)), a, 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 3)), 2, -1, st, rv);
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)), 1);
    end

    idle(2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_bridge.md
LINE_BRIDGE -- requirements
Module: line_bridge

Interface
REQ-001 Parameter LINE_WORDS, default 4, SHALL set the words per line buffer and per cached refill burst; it SHALL be a power of two in the range 2..16.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 cpu_en  in  1  access request; held, with all cpu_* inputs stable, while cpu_stall=1.
REQ-005 cpu_wen  in  4  byte write enables; 4'h0 marks a read.
REQ-006 cpu_addr  in  32  physical address from address translation, word-aligned.
REQ-007 cpu_cached  in  1  1 = cacheable (kseg0/other); 0 = uncached (kseg1).
REQ-008 cpu_wdata  in  32  write data.
REQ-009 cpu_rdata  out  32  read data; valid in the cycle cpu_en=1, read, and cpu_stall=0.
REQ-010 cpu_stall  out  1  1 = hold the pipeline.
REQ-011 bus_req  out  1  address-phase request.
REQ-012 bus_gnt  in  1  address phase accepted when bus_req=1 and bus_gnt=1.
REQ-013 bus_wr, bus_burst  out  1 each  write / LINE_WORDS-beat incrementing read burst.
REQ-014 bus_addr  out  32;  bus_wstrb  out  4;  bus_wdata  out  32  request fields, stable while bus_req=1.
REQ-015 bus_rvalid  in  1;  bus_rdata  in  32  read beats, in increasing address order.
REQ-016 bus_bvalid  in  1  write completion pulse.

Function
REQ-017 The block SHALL hold one line buffer: a valid bit, a tag equal to cpu_addr[31:log2(LINE_WORDS)+2], and LINE_WORDS data words.
REQ-018 FSM states SHALL be IDLE, REQ, RDATA, WRESP and DONE.
REQ-019 Hit: in IDLE, a request with cpu_en=1, read, cpu_cached=1, valid=1 and matching tag SHALL give cpu_stall=0 combinationally and cpu_rdata = the buffered word at cpu_addr word offset; there SHALL be zero stall cycles.
REQ-020 Any other request in IDLE with cpu_en=1 SHALL drive cpu_stall=1, latch all cpu_* fields and move to REQ.
REQ-021 In REQ, bus_req=1; a cached read SHALL present the line-aligned address with bus_burst=1; an uncached read SHALL present cpu_addr with bus_burst=0; a write SHALL present cpu_addr, bus_wr=1, bus_wstrb=cpu_wen and bus_wdata=cpu_wdata.
REQ-022 On bus_gnt=1 in REQ: a read SHALL go to RDATA and a write SHALL go to WRESP; bus_req SHALL drop in the following cycle.
REQ-023 In RDATA, each bus_rvalid SHALL be captured; a burst SHALL write words 0..LINE_WORDS-1 into the buffer through a beat counter and SHALL finish on beat LINE_WORDS-1, setting valid and tag in the same edge; an uncached read SHALL finish on its single beat without touching the buffer.
REQ-024 In WRESP, bus_bvalid SHALL end the write; if the write address tag matches a valid line, valid SHALL be cleared, for both cached and uncached writes.
REQ-025 DONE SHALL last exactly one cycle with cpu_stall=0, and cpu_rdata SHALL equal the requested word for reads; the FSM SHALL then return to IDLE.
REQ-026 cpu_stall SHALL be 1 in REQ, RDATA and WRESP.
REQ-027 bus_rvalid or bus_bvalid arriving outside RDATA or WRESP SHALL be ignored.
REQ-028 bus_gnt and bus_rvalid in the same cycle SHALL not occur; the bus guarantees this.
REQ-029 A request in IDLE in the cycle after DONE SHALL be evaluated normally; a refilled line SHALL be hit-capable immediately.

Reset
REQ-030 resetn=0 SHALL at any time, including mid-burst, force: FSM to IDLE, valid=0, beat counter=0, bus_req=0, bus_wr=0, bus_burst=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, cpu_rdata=0.
REQ-031 cpu_stall SHALL follow REQ-019/020 from the IDLE state.
REQ-032 Buffer data words need not be reset.

Verification
REQ-033 Cached read miss at 0x0000_1008, LINE_WORDS=4, bus_gnt after 2 cycles, beats 0xA0..0xA3 -> one burst at 0x0000_1000; DONE returns 0xA2; stall cycles = 1 + 2 + 1 + 4.
REQ-034 Cached read at 0x0000_100C immediately after REQ-033 -> cpu_stall=0 in the same cycle; cpu_rdata=0xA3; no bus_req.
REQ-035 Uncached read at 0x0000_1004 with buffer valid -> single beat, bus_burst=0; data returned from the bus, not 0xA1; buffer unchanged.
REQ-036 Write of cpu_wen=4'h3 to 0x0000_1000 -> bus_wr=1, bus_wstrb=4'h3; after bus_bvalid the line is invalid; a next read of 0x0000_1004 misses.
REQ-037 resetn pulled low after beat 2 of a burst -> all outputs at reset values; after release, a read of the same line misses and reissues the full burst.
REQ-038 bus_rvalid pulses while IDLE -> no state change; cpu_rdata and buffer unchanged.
